pipe_skid_stage: RTL and testbench

//  Parametrised elastic pipeline stage for all inter-stage boundaries (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_stage.sv | 88 ++++++++
 tb/tb_pipe_skid_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: stage occupancy encoding,
// the default control width and the bit positions of each control enable.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int CTRL_W_DEF = 7;

    localparam int CTRL_WB_EN   = 0;
    localparam int CTRL_MEM_R   = 1;
    localparam int CTRL_MEM_W   = 2;
    localparam int CTRL_BRANCH  = 3;
    localparam int CTRL_JUMP    = 4;
    localparam int CTRL_ALU_IMM = 5;
    localparam int CTRL_RF_RD   = 6;

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer: 1-cycle latency, full throughput.
// in_ready decodes registered state only, so downstream stalls never form a combinational path upstream.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32*4 + 5*3,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int ENT_W = CTRL_W + DATA_W;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   skid_q, skid_d;
    logic [ENT_W-1:0]   in_ent;
    logic               in_fire;

    assign in_ent  = {in_ctrl, in_data};
    assign in_fire = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_ent;
                end
            end
            ONE: begin
                if (in_fire && out_ready) begin
                    main_d = in_ent;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_ent;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flushed input must not overwrite the payload still shown on out_data.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = out_valid ? main_q[ENT_W-1:DATA_W] : '0;
    assign out_data  = ((CLEAR_DATA != 0) && !out_valid) ? '0 : main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Drives two stage instances (data held vs. data cleared on bubbles) with directed and random
// handshakes, comparing every cycle against a bounded-queue reference model.
module tb_pipe_skid_stage;

    localparam int DW = 24;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] shown;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0)) dut_hold (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0)
    );

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1)) dut_clr (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two items; the head is what downstream sees.
    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic r, input logic f, input logic rs);
        bit ofire, ifire;
        ent_t e;
        if (rs) begin
            q.delete();
            shown = '0;
        end else begin
            ofire = (q.size() > 0) && r;
            ifire = v && (q.size() < 2);
            if (f) begin
                q.delete();
            end else begin
                if (ofire) void'(q.pop_front());
                if (ifire) begin
                    e.d = d;
                    e.c = c;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) shown = q[0].d;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed0, ed1;
        ev  = (q.size() > 0);
        ec  = ev ? q[0].c : '0;
        ed0 = ev ? q[0].d : shown;
        ed1 = ev ? q[0].d : '0;
        chk({tag, ":in_ready"},  64'(in_ready0),  64'(q.size() < 2));
        chk({tag, ":out_valid"}, 64'(out_valid0), 64'(ev));
        chk({tag, ":out_ctrl"},  64'(out_ctrl0),  64'(ec));
        chk({tag, ":out_data"},  64'(out_data0),  64'(ed0));
        chk({tag, ":clr_ctrl"},  64'(out_ctrl1),  64'(ec));
        chk({tag, ":clr_data"},  64'(out_data1),  64'(ed1));
        chk({tag, ":clr_rdy"},   64'(in_ready1),  64'(q.size() < 2));
    endtask

    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic r, input logic f, input logic rs);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        rst       = rs;
        @(posedge clk);
        model_edge(v, d, c, r, f, rs);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        shown = '0;

        cycle("rst", 0, '0, '0, 0, 0, 1);
        cycle("rst", 1, 24'hABCDEF, 7'h7F, 1, 1, 1);
        chk("post_rst_data", 64'(out_data0), 64'h0);
        chk("post_rst_rdy", 64'(in_ready0), 64'h1);

        // T1 stream
        for (int i = 1; i <= 8; i++) cycle("t1", 1, DW'(i), CW'(i), 1, 0, 0);
        cycle("t1_tail", 0, '0, '0, 1, 0, 0);

        // T2 backpressure
        cycle("t2", 1, 24'h00000A, 7'h01, 0, 0, 0);
        cycle("t2", 1, 24'h00000B, 7'h02, 0, 0, 0);
        chk("t2_full", 64'(in_ready0), 64'h0);
        cycle("t2_blocked", 1, 24'h00000C, 7'h04, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("t2_drain", 0, '0, '0, 1, 0, 0);

        // T3 flush while full
        cycle("t3", 1, 24'h0000A1, 7'h11, 0, 0, 0);
        cycle("t3", 1, 24'h0000B1, 7'h12, 0, 0, 0);
        cycle("t3_flush", 1, 24'h0000C1, 7'h13, 0, 1, 0);
        chk("t3_vld", 64'(out_valid0), 64'h0);
        for (int i = 0; i < 3; i++) cycle("t3_after", 0, '0, '0, 1, 0, 0);

        // T4 bubble ctrl
        cycle("t4", 1, 24'h000D01, 7'h7F, 1, 0, 0);
        cycle("t4_gap", 0, 24'h000D02, 7'h7F, 1, 0, 0);
        cycle("t4_gap", 1, 24'h000D03, 7'h7F, 1, 0, 0);
        chk("t4_ctrl", 64'(out_ctrl0), 64'h7F);
        cycle("t4_end", 0, '0, 7'h7F, 1, 0, 0);

        // T5 reset while holding two entries
        cycle("t5", 1, 24'h0000E1, 7'h21, 0, 0, 0);
        cycle("t5", 1, 24'h0000E2, 7'h22, 0, 0, 0);
        cycle("t5_rst", 0, '0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("t5_after", 0, '0, '0, 1, 0, 0);

        // T6 random soak
        for (int i = 0; i < 10000; i++) begin
            cycle("t6",
                  ($urandom % 4) != 0,
                  DW'($urandom),
                  CW'($urandom),
                  ($urandom % 4) != 0,
                  ($urandom % 64) == 0,
                  ($urandom % 512) == 0);
        end
        for (int i = 0; i < 3; i++) cycle("t6_drain", 0, '0, '0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
